weight_stream_reader: RTL and testbench

Read-side sequencer for a single-port layer weight BRAM (16-bit words, negedge-registered read port, read data valid at the next rising CLK edge). On START it walks the BRAM from address 0 to DEPTH-1, captures each word and streams it to the neuron MAC datapath over a valid/ready interface with full backpressure support. It replaces ad-hoc address counters in the ANN layer controllers and is the only agent driving the BRAM port during inference.

---
 rtl/weight_stream_reader.sv | 158 +++++++++++++++
 tb/tb_weight_stream_reader.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_stream_reader.sv
// weight_stream_reader
//   Read-side sequencer for a single-port layer weight BRAM. On START it reads
//   addresses 0..DEPTH-1 (one read per cycle while credit allows), captures each
//   word one cycle after issue and streams it to the MAC over valid/ready.
//   A 2-entry {data,index} FIFO absorbs the one-cycle BRAM latency so that
//   backpressure never drops or duplicates a word.
//
//   Optional feature macro: WEIGHT_READER_CHECKSUM_EN
//     defined     -> CHECKSUM is the modulo-2**DATA_W sum of handshaken words
//                    of the current pass (cleared when START is accepted)
//     not defined -> CHECKSUM tied to 0, no accumulator
//
// Ports
//   CLK, RST_N          clock, asynchronous active-low reset
//   START               begin a pass (sampled only in IDLE)
//   BUSY, DONE          pass in progress / one-cycle completion pulse
//   BRAM_ADDR/EN/WE/DI  BRAM port (registered address/enable, write tied off)
//   BRAM_DO             BRAM read data, valid at the edge after the issue edge
//   W_DATA/W_VALID/W_READY/W_LAST/W_INDEX  weight stream to the MAC
//   CHECKSUM            running sum of delivered words (see macro above)
module weight_stream_reader #(
   parameter int DEPTH  = 28,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              START,
   output logic              BUSY,
   output logic              DONE,
   output logic [ADDR_W-1:0] BRAM_ADDR,
   output logic              BRAM_EN,
   output logic              BRAM_WE,
   output logic [DATA_W-1:0] BRAM_DI,
   input  logic [DATA_W-1:0] BRAM_DO,
   output logic [DATA_W-1:0] W_DATA,
   output logic              W_VALID,
   input  logic              W_READY,
   output logic              W_LAST,
   output logic [ADDR_W-1:0] W_INDEX,
   output logic [DATA_W-1:0] CHECKSUM
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] issue_ptr;
   logic [ADDR_W-1:0] issue_addr;
   logic [DATA_W-1:0] fifo_data [2];
   logic [ADDR_W-1:0] fifo_idx  [2];
   logic              rd_ptr, wr_ptr;
   logic [1:0]        count, count_after;
   logic              pop, capture, issue, start_acc;

   // A read issued in the previous cycle (BRAM_EN high) lands in the FIFO now.
   assign pop         = W_VALID & W_READY;
   assign capture     = BRAM_EN;
   assign count_after = count + {1'b0, capture} - {1'b0, pop};

   // The first read of a pass always targets address 0.
   assign issue_addr  = start_acc ? '0 : issue_ptr;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;
   end

   // Credit: buffered words plus in-flight reads after this edge must stay <= 2,
   // so a new read is issued only when at most one slot is committed.
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      start_acc = 1'b0;
      case (state)
         IDLE: begin
            if (START) begin
               start_acc = 1'b1;
               issue     = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (count_after < 2'd2) begin
               issue = 1'b1;
               if (issue_ptr == LAST_ADDR) state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            if (pop && W_LAST) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // BRAM port: address holds its last value when no read is issued.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         BRAM_EN   <= 1'b0;
         BRAM_ADDR <= '0;
         issue_ptr <= '0;
      end else begin
         BRAM_EN <= issue;
         if (issue) begin
            BRAM_ADDR <= issue_addr;
            issue_ptr <= issue_addr + 1'b1;
         end
      end
   end

   // Two-entry output FIFO; head drives the stream outputs.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < 2; i++) begin
            fifo_data[i] <= '0;
            fifo_idx[i]  <= '0;
         end
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (capture) begin
            fifo_data[wr_ptr] <= BRAM_DO;
            fifo_idx[wr_ptr]  <= BRAM_ADDR;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count_after;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) DONE <= 1'b0;
      else        DONE <= (state == FLUSH) && pop && W_LAST;
   end

`ifdef WEIGHT_READER_CHECKSUM_EN
   logic [DATA_W-1:0] sum;
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)         sum <= '0;
      else if (start_acc) sum <= '0;
      else if (pop)       sum <= sum + W_DATA;
   end
   assign CHECKSUM = sum;
`else
   assign CHECKSUM = '0;
`endif

   assign BUSY    = (state != IDLE);
   assign W_VALID = (count != 2'd0);
   assign W_DATA  = fifo_data[rd_ptr];
   assign W_INDEX = fifo_idx[rd_ptr];
   assign W_LAST  = W_VALID && (fifo_idx[rd_ptr] == LAST_ADDR);
   assign BRAM_WE = 1'b0;
   assign BRAM_DI = '0;

endmodule

// File: tb/tb_weight_stream_reader.sv
module tb_weight_stream_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, start2;
   logic        busy, done, bram_en, bram_we, w_valid, w_ready, w_last;
   logic [4:0]  bram_addr, w_index;
   logic [15:0] bram_di, bram_do, w_data, checksum;
   logic        busy2, done2, bram_en2, bram_we2, w_valid2, w_ready2, w_last2;
   logic [4:0]  bram_addr2, w_index2;
   logic [15:0] bram_di2, bram_do2, w_data2, checksum2;

   logic [15:0] mem  [32];
   logic [15:0] mem2 [32];

   int nvec = 0;
   int nfail = 0;

   // monitor state (written only by the monitor process)
   logic [21:0] q [$];
   int          done_cnt = 0;
   int          stall_err = 0;
   int          we_err = 0;
   int          mon_iss = 0;
   int          mon_hs = 0;
   int          max_out = 0;
   logic        prev_stall = 1'b0;
   logic [21:0] prev_word = '0;

   always #5 clk = ~clk;

   weight_stream_reader #(.DEPTH(28), .ADDR_W(5), .DATA_W(16)) dut (
      .CLK(clk), .RST_N(rst_n), .START(start), .BUSY(busy), .DONE(done),
      .BRAM_ADDR(bram_addr), .BRAM_EN(bram_en), .BRAM_WE(bram_we), .BRAM_DI(bram_di),
      .BRAM_DO(bram_do), .W_DATA(w_data), .W_VALID(w_valid), .W_READY(w_ready),
      .W_LAST(w_last), .W_INDEX(w_index), .CHECKSUM(checksum));

   weight_stream_reader #(.DEPTH(2), .ADDR_W(5), .DATA_W(16)) dut2 (
      .CLK(clk), .RST_N(rst_n), .START(start2), .BUSY(busy2), .DONE(done2),
      .BRAM_ADDR(bram_addr2), .BRAM_EN(bram_en2), .BRAM_WE(bram_we2), .BRAM_DI(bram_di2),
      .BRAM_DO(bram_do2), .W_DATA(w_data2), .W_VALID(w_valid2), .W_READY(w_ready2),
      .W_LAST(w_last2), .W_INDEX(w_index2), .CHECKSUM(checksum2));

   // negedge-registered BRAM read ports
   always @(negedge clk) begin
      if (bram_en)  bram_do  <= mem[bram_addr];
      if (bram_en2) bram_do2 <= mem2[bram_addr2];
   end

   // stream monitor for the DEPTH=28 instance
   always @(negedge clk) begin
      if (bram_we !== 1'b0 || bram_di !== 16'h0 || bram_we2 !== 1'b0 || bram_di2 !== 16'h0)
         we_err++;
      if (!rst_n) begin
         prev_stall = 1'b0;
         mon_iss = 0;
         mon_hs = 0;
      end else begin
         if (prev_stall && ({w_last, w_index, w_data} !== prev_word)) stall_err++;
         if (bram_en) mon_iss++;
         if (mon_iss - mon_hs > max_out) max_out = mon_iss - mon_hs;
         if (w_valid && w_ready) begin
            q.push_back({w_last, w_index, w_data});
            mon_hs++;
         end
         if (done) done_cnt++;
         prev_stall = w_valid && !w_ready;
         prev_word  = {w_last, w_index, w_data};
      end
   end

   task automatic start_pass();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = -1;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk); #1;
         if (done) begin
            n = i;
            return;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; start2 = 1'b0; w_ready = 1'b1; w_ready2 = 1'b1;
      #2;
      nvec++;
      if ({busy, done, bram_en, bram_we, w_valid, w_last} !== 6'b0) begin
         nfail++; $display("FAIL reset_ctrl: got %b required 000000", {busy, done, bram_en, bram_we, w_valid, w_last});
      end
      nvec++;
      if ({bram_addr, w_index, bram_di, w_data, checksum} !== 58'h0) begin
         nfail++; $display("FAIL reset_data: got %h required 0", {bram_addr, w_index, bram_di, w_data, checksum});
      end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(posedge clk); #1;
      nvec++;
      if ({busy, bram_en, w_valid} !== 3'b0) begin
         nfail++; $display("FAIL idle_after_reset: got %b required 000", {busy, bram_en, w_valid});
      end
   endtask

   task automatic test_stream();
      int n, base;
      logic [15:0] exp_ck;
      base = q.size();
      w_ready = 1'b1;
      start_pass();  // now just after accept edge k
      nvec++;
      if ({busy, bram_en, bram_addr, w_valid} !== {1'b1, 1'b1, 5'd0, 1'b0}) begin
         nfail++; $display("FAIL issue_k: got busy/en/addr/valid %b %b %0d %b required 1 1 0 0", busy, bram_en, bram_addr, w_valid);
      end
      @(posedge clk); #1;
      nvec++;
      if ({w_valid, w_data, w_index} !== {1'b1, 16'd1, 5'd0}) begin
         nfail++; $display("FAIL first_word: got valid/data/idx %b %0d %0d required 1 1 0", w_valid, w_data, w_index);
      end
      wait_done(n);
      nvec++;
      if (n !== 28) begin
         nfail++; $display("FAIL done_latency: got %0d edges after k+1 required 28", n);
      end
      nvec++;
      if (busy !== 1'b0) begin
         nfail++; $display("FAIL busy_in_done: got %b required 0", busy);
      end
`ifdef WEIGHT_READER_CHECKSUM_EN
      exp_ck = 16'd406;
`else
      exp_ck = 16'd0;
`endif
      nvec++;
      if (checksum !== exp_ck) begin
         nfail++; $display("FAIL checksum_28: got %0d required %0d", checksum, exp_ck);
      end
      @(posedge clk); #1;
      nvec++;
      if ({done, busy} !== 2'b00) begin
         nfail++; $display("FAIL done_pulse_width: got done/busy %b%b required 00", done, busy);
      end
      nvec++;
      if (q.size() - base !== 28) begin
         nfail++; $display("FAIL word_count: got %0d required 28", q.size() - base);
      end else begin
         for (int i = 0; i < 28; i++) begin
            nvec++;
            if (q[base+i] !== {(i == 27), 5'(i), 16'(i + 1)}) begin
               nfail++; $display("FAIL word_%0d: got %h required %h", i, q[base+i], {(i == 27), 5'(i), 16'(i + 1)});
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int base, bd, c;
      logic pat [4];
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      base = q.size(); bd = done_cnt; c = 0;
      start_pass();
      while (!done && c < 400) begin
         w_ready = pat[c % 4];
         @(posedge clk); #1;
         c++;
      end
      w_ready = 1'b1;
      nvec++;
      if (!done) begin
         nfail++; $display("FAIL bp_timeout: done got 0 required 1 within 400 cycles");
      end
      @(posedge clk); #1;
      nvec++;
      if (q.size() - base !== 28) begin
         nfail++; $display("FAIL bp_count: got %0d required 28", q.size() - base);
      end else begin
         for (int i = 0; i < 28; i++) begin
            nvec++;
            if (q[base+i] !== {(i == 27), 5'(i), 16'(i + 1)}) begin
               nfail++; $display("FAIL bp_word_%0d: got %h required %h", i, q[base+i], {(i == 27), 5'(i), 16'(i + 1)});
            end
         end
      end
      nvec++;
      if (stall_err !== 0) begin
         nfail++; $display("FAIL bp_stable: got %0d unstable stalls required 0", stall_err);
      end
      nvec++;
      if (max_out > 2) begin
         nfail++; $display("FAIL bp_outstanding: got %0d required <=2", max_out);
      end
      nvec++;
      if (done_cnt - bd !== 1) begin
         nfail++; $display("FAIL bp_done_count: got %0d required 1", done_cnt - bd);
      end
   endtask

   task automatic test_start_midpass();
      int base, bd, c, n;
      base = q.size(); bd = done_cnt; c = 0;
      w_ready = 1'b1;
      start_pass();
      while (q.size() - base < 10 && c < 100) begin
         @(posedge clk); #1; c++;
      end
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1 start = 1'b0;
      wait_done(n);
      repeat (5) @(posedge clk); #1;
      nvec++;
      if (done_cnt - bd !== 1) begin
         nfail++; $display("FAIL midstart_done_count: got %0d required 1", done_cnt - bd);
      end
      nvec++;
      if (q.size() - base !== 28) begin
         nfail++; $display("FAIL midstart_words: got %0d required 28", q.size() - base);
      end
      nvec++;
      if ({busy, bram_en} !== 2'b00) begin
         nfail++; $display("FAIL midstart_idle: got busy/en %b%b required 00", busy, bram_en);
      end
   endtask

   task automatic test_reset_midpass();
      int base, c, n;
      base = q.size(); c = 0;
      w_ready = 1'b1;
      start_pass();
      while (q.size() - base < 15 && c < 100) begin
         @(posedge clk); #1; c++;
      end
      w_ready = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      nvec++;
      if ({busy, done, bram_en, w_valid, w_last} !== 5'b0) begin
         nfail++; $display("FAIL async_reset_ctrl: got %b required 00000", {busy, done, bram_en, w_valid, w_last});
      end
      nvec++;
      if ({bram_addr, w_index, w_data, checksum} !== 42'h0) begin
         nfail++; $display("FAIL async_reset_data: got %h required 0", {bram_addr, w_index, w_data, checksum});
      end
      @(posedge clk); #1 rst_n = 1'b1;
      w_ready = 1'b1;
      base = q.size();
      start_pass();
      wait_done(n);
      nvec++;
      if (n !== 29) begin
         nfail++; $display("FAIL restart_latency: got %0d required 29", n);
      end
      nvec++;
      if (q.size() - base !== 28 || q[base] !== {1'b0, 5'd0, 16'd1}) begin
         nfail++; $display("FAIL restart_from_zero: got count %0d first %h required 28 000001", q.size() - base, (q.size() > base) ? q[base] : 22'h0);
      end
   endtask

   task automatic test_back_to_back();
      int base, n;
      base = q.size();
      w_ready = 1'b1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1;
      wait_done(n);
      nvec++;
      if (n !== 29 || busy !== 1'b0) begin
         nfail++; $display("FAIL b2b_first_done: got edges %0d busy %b required 29 0", n, busy);
      end
      @(posedge clk); #1;
      nvec++;
      if ({busy, bram_en, bram_addr, checksum} !== {1'b1, 1'b1, 5'd0, 16'd0}) begin
         nfail++; $display("FAIL b2b_accept_in_done: got busy/en/addr/ck %b %b %0d %0d required 1 1 0 0", busy, bram_en, bram_addr, checksum);
      end
      start = 1'b0;
      wait_done(n);
      nvec++;
      if (n !== 29) begin
         nfail++; $display("FAIL b2b_second_done: got %0d required 29", n);
      end
      @(posedge clk); #1;
      nvec++;
      if (q.size() - base !== 56) begin
         nfail++; $display("FAIL b2b_words: got %0d required 56", q.size() - base);
      end else begin
         nvec++;
         if (q[base+28] !== {1'b0, 5'd0, 16'd1} || q[base+55] !== {1'b1, 5'd27, 16'd28}) begin
            nfail++; $display("FAIL b2b_boundary: got %h %h required 000001 3b001c", q[base+28], q[base+55]);
         end
      end
      nvec++;
      if (we_err !== 0) begin
         nfail++; $display("FAIL bram_write_port: got %0d nonzero samples required 0", we_err);
      end
   endtask

   task automatic test_depth2();
      logic [15:0] exp_ck;
`ifdef WEIGHT_READER_CHECKSUM_EN
      exp_ck = 16'h0001;
`else
      exp_ck = 16'h0000;
`endif
      w_ready2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      nvec++;
      if ({busy2, bram_en2, bram_addr2} !== {1'b1, 1'b1, 5'd0}) begin
         nfail++; $display("FAIL d2_issue: got %b %b %0d required 1 1 0", busy2, bram_en2, bram_addr2);
      end
      @(posedge clk); #1;
      nvec++;
      if ({w_valid2, w_last2, w_index2, w_data2} !== {1'b1, 1'b0, 5'd0, 16'hFFFF}) begin
         nfail++; $display("FAIL d2_word0: got %b %b %0d %h required 1 0 0 ffff", w_valid2, w_last2, w_index2, w_data2);
      end
      @(posedge clk); #1;
      nvec++;
      if ({w_valid2, w_last2, w_index2, w_data2} !== {1'b1, 1'b1, 5'd1, 16'h0002}) begin
         nfail++; $display("FAIL d2_word1: got %b %b %0d %h required 1 1 1 0002", w_valid2, w_last2, w_index2, w_data2);
      end
      @(posedge clk); #1;
      nvec++;
      if ({done2, busy2, w_valid2} !== 3'b100 || checksum2 !== exp_ck) begin
         nfail++; $display("FAIL d2_done: got done/busy/valid %b%b%b ck %h required 100 %h", done2, busy2, w_valid2, checksum2, exp_ck);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         mem[i]  = 16'(i + 1);
         mem2[i] = 16'h0;
      end
      mem2[0] = 16'hFFFF;
      mem2[1] = 16'h0002;
      test_reset();
      test_stream();
      test_backpressure();
      test_start_midpass();
      test_reset_midpass();
      test_back_to_back();
      test_depth2();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
